// File: rtl/stopwatch_ctrl_if.sv
// Command, frame-sync and digit signals exchanged between the stopwatch
// controller and its surroundings (button FSM, counter datapath, renderer).
interface stopwatch_ctrl_if;
  logic        startstop_p;
  logic        lap_p;
  logic        clear_p;
  logic        vs;
  logic [19:0] cnt_digits;
  logic        count_en;
  logic        count_clr;
  logic [19:0] disp_digits;
  logic        running;
  logic        lap_active;

  modport master (
    output startstop_p, lap_p, clear_p, vs, cnt_digits,
    input  count_en, count_clr, disp_digits, running, lap_active
  );

  modport slave (
    input  startstop_p, lap_p, clear_p, vs, cnt_digits,
    output count_en, count_clr, disp_digits, running, lap_active
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/pause/lap FSM, tick prescaler with saturation at
// 9:59:59, and a frame-synchronous (tear-free) display register.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_e;

  localparam logic [25:0] PRESC_TOP  = 26'(TICK_DIV - 1);
  localparam logic [19:0] SAT_DIGITS = 20'h95959;

  state_e      state_q, state_d;
  logic [25:0] presc_q, presc_d;
  logic [19:0] snap_q, snap_d;
  logic [19:0] disp_q, disp_d;
  logic        count_en_q, count_en_d;
  logic        count_clr_q, count_clr_d;
  logic        vs_q;

  logic cmd_clr, cmd_ss, cmd_lap;
  logic active_q, active_d;
  logic tick_due, sat, frame;

  always_comb begin
    cmd_clr  = bus.clear_p;
    cmd_ss   = bus.startstop_p & ~bus.clear_p;
    cmd_lap  = bus.lap_p & ~bus.startstop_p & ~bus.clear_p;
    active_q = (state_q == RUN) || (state_q == LAP);
    tick_due = active_q && (presc_q == PRESC_TOP);
    sat      = tick_due && (bus.cnt_digits == SAT_DIGITS);
    frame    = vs_q & ~bus.vs;

    state_d     = state_q;
    snap_d      = snap_q;
    count_clr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_clr)     count_clr_d = 1'b1;
        else if (cmd_ss) state_d     = RUN;
      end
      RUN: begin
        if (cmd_ss) state_d = PAUSE;
        else if (cmd_lap) begin
          state_d = LAP;
          snap_d  = bus.cnt_digits;
        end
      end
      PAUSE: begin
        if (cmd_clr) begin
          count_clr_d = 1'b1;
          state_d     = IDLE;
        end else if (cmd_ss) begin
          state_d = RUN;
        end
      end
      LAP: begin
        if (cmd_ss)       state_d = PAUSE;
        else if (cmd_lap) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    // Saturation overrides any command and leaves the snapshot untouched.
    if (sat) begin
      state_d = PAUSE;
      snap_d  = snap_q;
    end
    active_d   = (state_d == RUN) || (state_d == LAP);
    count_en_d = tick_due & ~sat;

    // A stop freezes the prescaler on the stop cycle itself; a due tick still wraps it.
    presc_d = presc_q;
    if (count_clr_d || (state_q == IDLE && state_d == RUN)) presc_d = '0;
    else if (tick_due)                                      presc_d = '0;
    else if (active_q && active_d)                          presc_d = presc_q + 26'd1;

    disp_d = disp_q;
    if (frame) disp_d = (state_q == LAP) ? snap_q : bus.cnt_digits;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      snap_q      <= '0;
      disp_q      <= '0;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
      vs_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      snap_q      <= snap_d;
      disp_q      <= disp_d;
      count_en_q  <= count_en_d;
      count_clr_q <= count_clr_d;
      vs_q        <= bus.vs;
    end
  end

  assign bus.count_en    = count_en_q;
  assign bus.count_clr   = count_clr_q;
  assign bus.disp_digits = disp_q;
  assign bus.running     = active_q;
  assign bus.lap_active  = (state_q == LAP);

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, giving clk cycles per count tick (1 Hz at 50 MHz); legal range 2..2^26-1.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock for all logic, rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port startstop_p, input, 1 bit: one-cycle start/stop command pulse from the button FSM.
REQ-005 The block SHALL have port lap_p, input, 1 bit: one-cycle lap (freeze/unfreeze display) command pulse.
REQ-006 The block SHALL have port clear_p, input, 1 bit: one-cycle clear command pulse.
REQ-007 The block SHALL have port vs, input, 1 bit: VGA vertical sync, active-low, synchronous to clk.
REQ-008 The block SHALL have port cnt_digits, input, 20 bits: live counter value {h,m1,m0,s1,s0}, 4 bits each, h in [19:16].
REQ-009 The block SHALL have port count_en, output, 1 bit: one-cycle advance strobe to the counter datapath.
REQ-010 The block SHALL have port count_clr, output, 1 bit: one-cycle synchronous clear strobe to the counter datapath.
REQ-011 The block SHALL have port disp_digits, output, 20 bits: tear-free digits for the segment renderer, same packing as cnt_digits.
REQ-012 The block SHALL have ports running and lap_active, outputs, 1 bit each: status (state is RUN/LAP; state is LAP).

Function
REQ-013 The state machine SHALL have states IDLE, RUN, PAUSE and LAP (running, display frozen).
REQ-014 Command priority SHALL be clear_p > startstop_p > lap_p on the same cycle; lower-priority pulses on that cycle SHALL be discarded.
REQ-015 Transitions SHALL be: IDLE--startstop-->RUN; RUN--startstop-->PAUSE; PAUSE--startstop-->RUN; RUN--lap-->LAP; LAP--lap-->RUN; LAP--startstop-->PAUSE; IDLE/PAUSE--clear-->IDLE.
REQ-016 clear_p in RUN or LAP SHALL be ignored; lap_p in IDLE or PAUSE SHALL be ignored.
REQ-017 count_clr SHALL pulse high for exactly one cycle, the cycle after an accepted clear_p.
REQ-018 A 26-bit prescaler SHALL count 0..TICK_DIV-1 in RUN and LAP, wrap to 0, and hold its value in PAUSE.
REQ-019 The prescaler SHALL be zeroed on IDLE->RUN and on accepted clear.
REQ-020 count_en SHALL pulse for one cycle, registered, on the cycle after the prescaler reads TICK_DIV-1 in RUN or LAP, so the first tick after start occurs TICK_DIV cycles after the start edge.
REQ-021 Saturation: if a tick is due while cnt_digits == 0x95959, count_en SHALL stay low and the state SHALL go to PAUSE; the display SHALL hold 9:59:59.
REQ-022 The block SHALL detect a vs falling edge (registered vs 1, current 0) as the frame boundary.
REQ-023 In IDLE, RUN and PAUSE, disp_digits SHALL load cnt_digits only on the cycle after a frame boundary, and SHALL hold otherwise.
REQ-024 On accepted lap_p from RUN, a snapshot register SHALL capture cnt_digits on that cycle.
REQ-025 While in LAP, disp_digits SHALL load the snapshot at the next frame boundary and SHALL not follow cnt_digits.
REQ-026 On leaving LAP, live updates SHALL resume from the next frame boundary.
REQ-027 A tick and a command on the same cycle SHALL both take effect: the tick is emitted, then the state changes.

Reset
REQ-028 While rst is high, all state SHALL be cleared asynchronously: state=IDLE, prescaler=0, snapshot=0, disp_digits=0, count_en=0, count_clr=0, running=0, lap_active=0, vs edge register=1.
REQ-029 Assertion of rst mid-run or mid-lap SHALL abort to IDLE with no count_en or count_clr pulse emitted on or after the reset edge.

Verification
REQ-030 With TICK_DIV=4, startstop_p from IDLE -> running=1; count_en pulses every 4 cycles, first one 4 cycles after the start pulse.
REQ-031 In RUN with the prescaler at 2, issue startstop_p, wait 10 cycles, then startstop_p -> no count_en while paused; the next count_en arrives 2 cycles after resume.
REQ-032 Set cnt_digits=0x00012 and send lap_p; then change cnt_digits to 0x00015 across 3 vs falling edges -> disp_digits=0x00012. After a second lap_p, disp_digits=0x00015 one cycle after the next vs fall.
REQ-033 clear_p and startstop_p on the same cycle in PAUSE -> count_clr single pulse and state IDLE; clear_p in RUN -> no count_clr.
REQ-034 Hold cnt_digits=0x95959 in RUN -> no count_en; state PAUSE when the tick is due.
REQ-035 Assert rst for 1 cycle mid-LAP -> all outputs 0 immediately (asynchronously); the subsequent startstop_p restarts cleanly.
